// File: rtl/ram_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_pkg
//   Shared definitions for the RAM read-stream engine:
//     state_e     - sequencer states (IDLE, RUN, DRAIN, DONE), 2 bits
//     RD_LAT      - RAM read latency in cycles (registered read port)
//     SKID_DEPTH  - entries in the return-path buffer
//     SKID_CNT_W  - width of an occupancy count of 0..SKID_DEPTH
// ---------------------------------------------------------------------------
package ram_stream_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned SKID_DEPTH = 2;
    localparam int unsigned SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage : ram_stream_reader_pkg

// File: rtl/rd_skid_buf.sv
// ---------------------------------------------------------------------------
// rd_skid_buf
//   Small FIFO that catches RAM read data while the downstream consumer
//   stalls. Push and pop may happen in the same cycle. Head data is taken
//   straight from storage, so it only changes on a pop or a push to an
//   empty buffer.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   push_i          write push_data_i at the tail this cycle
//   push_data_i     data to write
//   pop_i           drop the head entry this cycle (caller never pops empty)
//   count_o         number of valid entries, 0..SKID_DEPTH
//   head_o          oldest entry (zero after reset)
// ---------------------------------------------------------------------------
module rd_skid_buf
    import ram_stream_reader_pkg::*;
#(
    parameter int Data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic [Data_width-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [SKID_CNT_W-1:0] count_o,
    output logic [Data_width-1:0] head_o
);

    localparam int unsigned PTR_W = $clog2(SKID_DEPTH);

    logic [Data_width-1:0] mem_q [SKID_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [SKID_CNT_W-1:0] count_q;

    // NOTE: state registers take non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the storage is cleared on reset (it is only two words)
            // so that the head output reads zero out of reset; deep
            // memories would normally be left unreset.
            for (int i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + SKID_CNT_W'(push_i) - SKID_CNT_W'(pop_i);
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule : rd_skid_buf

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
//   Sweeps a contiguous, wrap-around address range through a RAM read port
//   with a registered 1-cycle read, and delivers each word on a valid/ready
//   stream without loss or duplication under backpressure.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   start           command strobe, sampled only in IDLE
//   base_addr       first address, sampled with start
//   len             word count 0..2**Addr_width, sampled with start
//   busy            high from the cycle after an accepted non-empty command
//                   through its done cycle
//   done            one-cycle pulse once the last word is accepted
//   r_addr          registered RAM read address
//   ram_q           RAM read data, valid one cycle after r_addr
//   m_data/m_valid  output stream, m_ready from the consumer
//
// Address handling: r_addr itself is the address counter. The RAM captures
// r_addr at the edge that ends an issue cycle, so issuing advances r_addr
// for the next read -- except for the last read, which leaves r_addr
// parked on the last issued address.
// ---------------------------------------------------------------------------
module ram_stream_reader
    import ram_stream_reader_pkg::*;
#(
    parameter int Data_width = 8,
    parameter int Addr_width = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [Addr_width-1:0] base_addr,
    input  logic [Addr_width:0]   len,
    output logic                  busy,
    output logic                  done,
    output logic [Addr_width-1:0] r_addr,
    input  logic [Data_width-1:0] ram_q,
    output logic [Data_width-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);

    // One extra bit so occupancy arithmetic never wraps.
    localparam int unsigned OCC_W = SKID_CNT_W + 1;

    state_e                state_q,    state_d;
    logic [Addr_width-1:0] r_addr_q,   r_addr_d;
    logic [Addr_width:0]   rem_q,      rem_d;
    logic [RD_LAT-1:0]     inflight_q, inflight_d;
    logic                  busy_q,     busy_d;

    logic [SKID_CNT_W-1:0] buf_count;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      buf_count_next;
    logic [RD_LAT:0]       inflight_sh;

    // The oldest inflight stage is the one whose data is on ram_q now.
    assign push    = inflight_q[RD_LAT-1];
    assign pop     = m_valid & m_ready;
    assign m_valid = (buf_count != '0);

    rd_skid_buf #(
        .Data_width (Data_width)
    ) u_skid (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (ram_q),
        .pop_i       (pop),
        .count_o     (buf_count),
        .head_o      (m_data)
    );

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can leave a value unassigned (a latch).
        state_d  = state_q;
        r_addr_d = r_addr_q;
        rem_d    = rem_q;
        busy_d   = busy_q;

        // Words that will occupy the buffer once everything in flight lands;
        // issuing only below SKID_DEPTH is what keeps the buffer from
        // overflowing when the consumer stalls.
        occ            = OCC_W'(buf_count) + OCC_W'($countones(inflight_q)) - OCC_W'(pop);
        buf_count_next = OCC_W'(buf_count) + OCC_W'(push) - OCC_W'(pop);
        issue          = (state_q == ST_RUN) && (rem_q != '0) && (occ < OCC_W'(SKID_DEPTH));

        inflight_sh = {inflight_q, issue};
        inflight_d  = inflight_sh[RD_LAT-1:0];

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d  = ST_RUN;
                        r_addr_d = base_addr;
                        rem_d    = len;
                        busy_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rem_d = rem_q - (Addr_width + 1)'(1);
                    if (rem_q == (Addr_width + 1)'(1)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        r_addr_d = r_addr_q + Addr_width'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once this edge empties both the pipe and the buffer.
                if (buf_count_next == '0 && inflight_d == '0) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            r_addr_q   <= '0;
            rem_q      <= '0;
            inflight_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_addr_q   <= r_addr_d;
            rem_q      <= rem_d;
            inflight_q <= inflight_d;
            busy_q     <= busy_d;
        end
    end

    // busy is a flag rather than a state decode: a zero-length command
    // passes through DONE without ever raising busy.
    assign busy   = busy_q;
    assign done   = (state_q == ST_DONE);
    assign r_addr = r_addr_q;

endmodule : ram_stream_reader

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
//   Self-checking bench for ram_stream_reader. The RAM is modelled as a
//   registered read returning data[a] = a[7:0]. Expected stream contents come
//   from a queue filled with (base + i) mod 1024; cycle expectations come
//   from the documented latency (first data in cycle 3, done in cycle N+3).
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [9:0]  r_addr;
    logic [7:0]  ram_q;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_ready;

    int n_checks = 0;
    int n_pass   = 0;

    ram_stream_reader #(
        .Data_width (8),
        .Addr_width (10)
    ) dut (
        .clk       (clk),
        .reset     (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .r_addr    (r_addr),
        .ram_q     (ram_q),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read port model: registered read of data[a] = a[7:0].
    initial ram_q = '0;
    always @(posedge clk) ram_q <= r_addr[7:0];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one command from the IDLE cycle in which start is driven. Cycle
    // numbering: cycle 1 is the one after the edge that samples start.
    task automatic run_cmd(input logic [9:0] base, input int n, input bit bp, input int poke,
                           output int done_cyc, output int busy_cnt, output int first_valid);
        logic [7:0] exp_q [$];
        int         budget;
        int         low_left;
        bit         prev_stall;
        logic [7:0] prev_data;

        for (int i = 0; i < n; i++) exp_q.push_back(8'((int'(base) + i) % 1024));
        done_cyc    = -1;
        busy_cnt    = 0;
        first_valid = -1;
        low_left    = 0;
        prev_stall  = 1'b0;
        prev_data   = '0;
        budget      = bp ? 8 * n + 64 : n + 64;

        start     = 1'b1;
        base_addr = base;
        len       = 11'(n);
        m_ready   = 1'b1;

        for (int cyc = 1; cyc <= budget && done_cyc < 0; cyc++) begin
            tick();
            start = 1'b0;
            if (cyc == poke) begin
                start     = 1'b1;
                base_addr = 10'h200;
                len       = 11'd9;
            end
            if (bp) begin
                if (low_left > 0) begin
                    m_ready = 1'b0;
                    low_left--;
                end else if ($urandom_range(0, 2) == 0) begin
                    m_ready  = 1'b0;
                    low_left = $urandom_range(0, 4);
                end else begin
                    m_ready = 1'b1;
                end
            end

            if (busy) busy_cnt++;
            if (prev_stall) begin
                check("valid held under stall", 32'(m_valid), 1);
                check("data held under stall", 32'(m_data), 32'(prev_data));
            end
            if (m_valid && first_valid < 0) first_valid = cyc;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) check("extra word", 1, 0);
                else check("stream word", 32'(m_data), 32'(exp_q.pop_front()));
            end
            if (bp) check("inflight+buffer<=2", 32'((32'(dut.buf_count) + 32'(dut.inflight_q)) <= 2), 1);
            if (!bp && n > 0 && cyc <= n)
                check("r_addr issue sequence", 32'(r_addr), 32'((int'(base) + cyc - 1) % 1024));
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (done) done_cyc = cyc;
        end

        if (done_cyc < 0) check("done within budget", 0, 1);
        check("words outstanding", 32'(exp_q.size()), 0);
        if (n > 0) check("r_addr holds last", 32'(r_addr), 32'((int'(base) + n - 1) % 1024));
        tick();
        start   = 1'b0;
        m_ready = 1'b1;
        check("done is one cycle", 32'(done), 0);
    endtask

    typedef struct {
        logic [9:0] base;
        int         n;
        bit         bp;
        int         poke;
        int         exp_done;   // -1: timing depends on backpressure
    } vec_t;

    vec_t vecs [7];

    initial begin
        int done_cyc, busy_cnt, first_valid, words, done_seen;

        vecs[0] = '{base: 10'h010, n: 4,    bp: 1'b0, poke: 0, exp_done: 7};
        vecs[1] = '{base: 10'h3FE, n: 4,    bp: 1'b0, poke: 0, exp_done: 7};
        vecs[2] = '{base: 10'h155, n: 0,    bp: 1'b0, poke: 0, exp_done: 1};
        vecs[3] = '{base: 10'h3FF, n: 1,    bp: 1'b0, poke: 0, exp_done: 4};
        vecs[4] = '{base: 10'h010, n: 4,    bp: 1'b0, poke: 2, exp_done: 7};
        vecs[5] = '{base: 10'h0A0, n: 8,    bp: 1'b1, poke: 0, exp_done: -1};
        vecs[6] = '{base: 10'h000, n: 1024, bp: 1'b0, poke: 0, exp_done: 1027};

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        len       = '0;
        m_ready   = 1'b0;
        @(negedge clk);
        check("reset busy",    32'(busy),    0);
        check("reset done",    32'(done),    0);
        check("reset m_valid", 32'(m_valid), 0);
        check("reset m_data",  32'(m_data),  0);
        check("reset r_addr",  32'(r_addr),  0);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].base, vecs[v].n, vecs[v].bp, vecs[v].poke, done_cyc, busy_cnt, first_valid);
            if (vecs[v].exp_done >= 0) check("done cycle", 32'(done_cyc), 32'(vecs[v].exp_done));
            check("busy cycle count", 32'(busy_cnt), 32'(vecs[v].n == 0 ? 0 : done_cyc));
            if (vecs[v].n == 0) check("no valid for len 0", 32'(first_valid), 32'(-1));
            else if (!vecs[v].bp) check("first data cycle", 32'(first_valid), 3);
        end

        // Random commands under random backpressure.
        for (int r = 0; r < 6; r++) begin
            logic [9:0] b;
            int         n;
            b = 10'($urandom_range(0, 1023));
            n = $urandom_range(1, 40);
            run_cmd(b, n, 1'b1, 0, done_cyc, busy_cnt, first_valid);
            check("rand done not early", 32'(done_cyc >= n + 3), 1);
            check("rand busy cycle count", 32'(busy_cnt), 32'(done_cyc));
        end

        // Asynchronous reset after the third word has been accepted.
        start     = 1'b1;
        base_addr = 10'h020;
        len       = 11'd8;
        m_ready   = 1'b1;
        words     = 0;
        for (int c = 1; c <= 5; c++) begin
            tick();
            start = 1'b0;
            if (m_valid) words++;
        end
        check("words before reset", 32'(words), 3);
        tick();
        check("busy before reset", 32'(busy), 1);
        check("valid before reset", 32'(m_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("abort busy",    32'(busy),    0);
        check("abort done",    32'(done),    0);
        check("abort m_valid", 32'(m_valid), 0);
        check("abort m_data",  32'(m_data),  0);
        check("abort r_addr",  32'(r_addr),  0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst       = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (done || busy || m_valid) done_seen++;
        end
        check("quiet after abort", 32'(done_seen), 0);
        run_cmd(10'h100, 2, 1'b0, 0, done_cyc, busy_cnt, first_valid);
        check("post-reset done cycle", 32'(done_cyc), 5);
        check("post-reset first data", 32'(first_valid), 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_ram_stream_reader

// File: doc/ram_stream_reader.md
# ram_stream_reader

Read-side engine for the dual-port block RAM. On a start command it sweeps a contiguous, wrap-around address range through the RAM read port and delivers each word on a valid/ready output stream. It handles the RAM's fixed 1-cycle registered read latency and absorbs downstream backpressure without losing or duplicating words. It sits between the RAM read port (`r_addr`/`q`) and any stream consumer, such as a UART TX or a VGA line fetch.

## Interface
- `Data_width`, 8, bits per RAM word; must match the RAM.
- `Addr_width`, 10, RAM address bits; depth is 2**Addr_width.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `start`  in  1  command strobe; sampled only in IDLE.
- `base_addr`  in  Addr_width  first address, sampled with `start`.
- `len`  in  Addr_width+1  word count, 0..2**Addr_width, sampled with `start`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  1-cycle pulse when the last word has been accepted downstream.
- `r_addr`  out  Addr_width  RAM read address, registered.
- `ram_q`  in  Data_width  RAM read data; valid 1 cycle after `r_addr` is presented.
- `m_data`  out  Data_width  stream data.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready from the consumer.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE to RUN when `start`=1 and `len`≠0. Latch `base_addr` into the address counter and `len` into the remaining-issue counter.
  - IDLE to DONE when `start`=1 and `len`=0. No reads are issued.
  - RUN to DRAIN in the cycle the last read is issued.
  - DRAIN to DONE once no read is in flight and the buffer is empty.
  - DONE to IDLE unconditionally. `done`=1 only while in DONE.
- `start` is ignored outside IDLE. `base_addr` and `len` are don't-care outside the start cycle.
- Read issue: a read is issued in a RUN cycle when (buffer count + inflight − pop) < 2.
  - pop = `m_valid` & `m_ready`.
  - Issuing a read drives the current address on `r_addr`, sets inflight for the next cycle, increments the address, and decrements the remaining count.
- Address arithmetic is Addr_width bits and wraps modulo 2**Addr_width. The sequence is 1023 then 0 for the default width.
- Return path: an inflight read writes `ram_q` into a 2-entry buffer in the following cycle. The buffer is FIFO-ordered.
  - `m_valid` = buffer not empty. `m_data` = buffer head.
  - Push and pop may occur in the same cycle.
  - The buffer can never overflow because of the issue rule.
- `m_valid`, once high, stays high and `m_data` stays stable until `m_ready`=1. This follows standard valid/ready rules.
- Between and after commands, `r_addr` holds its last issued value. RAM reads with no inflight flag set are discarded.
- Reset values:
  - FSM in IDLE.
  - `busy`=0, `done`=0, `m_valid`=0.
  - `m_data`=0, `r_addr`=0.
  - Counters, inflight flag, and buffer all cleared.
- Reset mid-command aborts the command. No `done` is emitted and the buffer is flushed.

## Timing
- `start` is sampled at edge E0. Cycle 1 (after E0): `busy`=1 and `r_addr`=base.
- Cycle 2: `ram_q` carries word[base]. Cycle 3: `m_valid`=1 with word[base].
- Start-to-first-data latency is 3 cycles.
- With `m_ready` held at 1, throughput is 1 word per cycle. `len`=N completes with `done` in cycle N+3, and `busy` falls in the same cycle that `done` is high.
- `len`=0: `done` pulses in cycle 1 and `busy` stays 0.
- When `m_ready` deasserts, issuing stops within 1 cycle. At most 2 words are held, and no words are lost.
- The earliest next `start` is accepted in the cycle after `done`.

## Structure
- A shared package holds:
  - the FSM state enum (IDLE, RUN, DRAIN, DONE), 2 bits;
  - the constant `RD_LAT`=1 (RAM read latency);
  - the buffer depth constant `SKID_DEPTH`=2.
- One sub-module, `rd_skid_buf`: a 2-entry FIFO with push/pop, count, head data and async reset. It is parameterised by Data_width.
- The top level holds the FSM, the address and remaining counters, the inflight flag and the issue logic.

## Test plan
- RAM preloaded with data[a]=a[7:0]; `base_addr`=0x010, `len`=4, `m_ready`=1.
  - Stream carries 0x10, 0x11, 0x12, 0x13 in consecutive cycles 3–6.
  - `done` pulses in cycle 7; `busy` is high in cycles 1–7.
- Wrap: `base_addr`=0x3FE, `len`=4.
  - `r_addr` sequence is 0x3FE, 0x3FF, 0x000, 0x001.
  - Data is 0xFE, 0xFF, 0x00, 0x01.
- Backpressure: `len`=8, with `m_ready` toggled by a pseudo-random pattern held low for up to 5 cycles.
  - All 8 words arrive in order with no duplicates.
  - `m_data` is stable while `m_valid`=1 and `m_ready`=0.
  - The inflight-plus-buffer total never exceeds 2.
- `len`=0 gives `done` in cycle 1, `busy`=0 throughout, and no `m_valid`. A `start` during RUN is ignored: the word count is unchanged.
- `reset` asserted asynchronously mid-command, after the 3rd word.
  - Outputs immediately return to their reset values and no `done` is emitted.
  - A new `start` with `len`=2 afterwards completes correctly.
- Full sweep: `base_addr`=0, `len`=1024, `m_ready`=1.
  - 1024 words arrive in order and `done` pulses in cycle 1027.
